instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/y86_pkg.sv | 38 +++
 rtl/instr_len.sv | 15 +
 rtl/instr_encoder.sv | 130 +++++++++++++
 tb/tb_instr_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes, encoder state type and instruction length lookup.
`default_nettype none
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } enc_state_t;

  // Encoded length in bytes; 0 marks an undefined icode.
  function automatic logic [3:0] icode_len(input logic [3:0] icode);
    logic [3:0] len;
    len = 4'd0;
    case (icode)
      I_HALT, I_NOP, I_RET:                 len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     len = 4'd2;
      I_JXX, I_CALL:                        len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         len = 4'd10;
      default:                              len = 4'd0;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_len.sv
// Combinational icode -> instruction length decoder.
`default_nettype none
module instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       valid
);

  assign len   = icode_len(icode);
  assign valid = (len != 4'd0);

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
// Y86-64 instruction encoder: turns one descriptor into a byte-write stream
// toward instruction memory and tracks the next-PC write pointer.
`default_nettype none
module instr_encoder
  import y86_pkg::*;
#(
  parameter logic [63:0] IMEM_TOP = 64'd2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  input  logic        base_load,
  input  logic [63:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_addr,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [63:0] wr_ptr,
  output logic        busy,
  output logic        inst_err,
  output logic        addr_err
);

  enc_state_t  state;
  logic [3:0]  len_q;
  logic [3:0]  idx;
  logic [3:0]  ra_q;
  logic [3:0]  rb_q;
  logic [63:0] valc_q;

  logic [3:0]  len;
  logic        len_ok;
  logic [64:0] end_addr;
  logic        range_err;
  logic [3:0]  idx_nxt;
  logic [2:0]  vidx;
  logic [7:0]  nxt_byte;

  instr_len u_len (
    .icode (icode),
    .len   (len),
    .valid (len_ok)
  );

  // 65-bit sum so a pointer near the top of the address space cannot wrap past the check.
  assign end_addr  = {1'b0, wr_ptr} + {61'd0, len} - 65'd1;
  assign range_err = (end_addr > {1'b0, IMEM_TOP});

  assign in_ready = ~rst & (state == ST_IDLE) & ~base_load;
  assign busy     = (state == ST_EMIT);
  assign idx_nxt  = idx + 4'd1;

  // valC starts at byte 2 for 10-byte forms and at byte 1 for 9-byte forms, MSB first.
  always_comb begin
    vidx     = (len_q == 4'd10) ? 3'(idx_nxt - 4'd2) : 3'(idx_nxt - 4'd1);
    nxt_byte = valc_q[{3'd7 - vidx, 3'b000} +: 8];
    if (idx_nxt == 4'd1 && (len_q == 4'd2 || len_q == 4'd10))
      nxt_byte = {ra_q, rb_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      inst_err  <= 1'b0;
      addr_err  <= 1'b0;
      len_q     <= '0;
      idx       <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      valc_q    <= '0;
    end else begin
      inst_err <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (base_load) begin
            wr_ptr <= base_addr;
          end else if (in_valid) begin
            if (!len_ok) begin
              inst_err <= 1'b1;
            end else if (range_err) begin
              addr_err <= 1'b1;
            end else begin
              state     <= ST_EMIT;
              len_q     <= len;
              idx       <= 4'd0;
              ra_q      <= rA;
              rb_q      <= rB;
              valc_q    <= valC;
              out_valid <= 1'b1;
              out_addr  <= wr_ptr;
              out_data  <= {icode, ifun};
              out_last  <= (len == 4'd1);
            end
          end
        end
        ST_EMIT: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              wr_ptr    <= wr_ptr + {60'd0, len_q};
            end else begin
              idx      <= idx_nxt;
              out_addr <= out_addr + 64'd1;
              out_data <= nxt_byte;
              out_last <= (idx_nxt == len_q - 4'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
`default_nettype none
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        base_load;
  logic [63:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_addr;
  logic [7:0]  out_data;
  logic        out_last;
  logic [63:0] wr_ptr;
  logic        busy, inst_err, addr_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_bytes [10];

  always #5 clk = ~clk;

  instr_encoder #(.IMEM_TOP(64'd2047)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .base_load(base_load), .base_addr(base_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .wr_ptr(wr_ptr),
    .busy(busy), .inst_err(inst_err), .addr_err(addr_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc);
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    in_valid = 1'b1;
    #1;
    chk("in_ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_base(input logic [63:0] a);
    base_load = 1'b1; base_addr = a;
    #1;
    chk("in_ready_during_base_load", in_ready, 0);
    tick();
    base_load = 1'b0;
    chk("wr_ptr_after_base_load", wr_ptr, a);
  endtask

  // Called one cycle after accept; checks n bytes from exp_bytes, optionally stalling at one index.
  task automatic stream(input logic [63:0] start, input int n, input int stall_at, input int stall_len);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("out_valid[%0d]", i), out_valid, 1);
      chk($sformatf("out_addr[%0d]", i), out_addr, start + 64'(i));
      chk($sformatf("out_data[%0d]", i), out_data, exp_bytes[i]);
      chk($sformatf("out_last[%0d]", i), out_last, (i == n - 1));
      chk($sformatf("busy[%0d]", i), busy, 1);
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk("stall_valid", out_valid, 1);
          chk("stall_addr", out_addr, start + 64'(i));
          chk("stall_data", out_data, exp_bytes[i]);
          chk("stall_last", out_last, (i == n - 1));
        end
        out_ready = 1'b1;
      end
      tick();
    end
    chk("out_valid_after_stream", out_valid, 0);
    chk("busy_after_stream", busy, 0);
    chk("in_ready_after_stream", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
    base_load = 1'b0; base_addr = '0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", in_ready, 1);

    // irmovq $4, %rax
    send(4'h3, 4'h0, 4'hF, 4'h0, 64'h4);
    exp_bytes = '{8'h30, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
    stream(64'd0, 10, -1, 0);
    chk("wr_ptr_irmovq", wr_ptr, 64'd10);

    // addq %rax, %rbx with a 3-cycle back-pressure stall
    send(4'h6, 4'h0, 4'h0, 4'h3, 64'h0);
    exp_bytes = '{8'h60, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    stream(64'd10, 2, 0, 3);
    chk("wr_ptr_opq", wr_ptr, 64'd12);

    // jxx to 0x0102030405060708 from 0x20
    load_base(64'h20);
    send(4'h7, 4'h3, 4'h0, 4'h0, 64'h0102030405060708);
    exp_bytes = '{8'h73, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
    stream(64'h20, 9, -1, 0);
    chk("wr_ptr_jxx", wr_ptr, 64'h29);

    // Undefined icode
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0);
    chk("inst_err_pulse", inst_err, 1);
    chk("inst_err_no_valid", out_valid, 0);
    chk("inst_err_idle", busy, 0);
    tick();
    chk("inst_err_clear", inst_err, 0);
    chk("inst_err_no_valid2", out_valid, 0);
    chk("wr_ptr_after_inst_err", wr_ptr, 64'h29);

    // halt
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
    exp_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    stream(64'h29, 1, -1, 0);
    chk("wr_ptr_halt", wr_ptr, 64'h2A);

    // rmmovq overflowing the top of memory
    load_base(64'd2040);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788);
    chk("addr_err_pulse", addr_err, 1);
    chk("addr_err_no_valid", out_valid, 0);
    tick();
    chk("addr_err_clear", addr_err, 0);
    chk("addr_err_no_valid2", out_valid, 0);
    chk("wr_ptr_after_addr_err", wr_ptr, 64'd2040);

    // rmmovq ending exactly at the top byte
    load_base(64'd2038);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788);
    chk("fit_no_addr_err", addr_err, 0);
    exp_bytes = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    stream(64'd2038, 10, -1, 0);
    chk("wr_ptr_top", wr_ptr, 64'd2048);

    // Reset in the middle of an irmovq
    load_base(64'h40);
    send(4'h3, 4'h0, 4'hF, 4'h1, 64'hAABBCCDDEEFF0011);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_busy_before_rst", busy, 1);
    chk("mid_addr_before_rst", out_addr, 64'h45);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_addr", out_addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_wr_ptr", wr_ptr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    tick();
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_wr_ptr", wr_ptr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
